// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - two-port round-robin shared 16-bit signed multiplier
// MULT_OVF_EN builds the full 32-bit product and drives res_ovf; otherwise res_ovf is tied to 0.
module mult_share_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_id,
  output logic        res_ovf,
  input  logic        res_ready
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        grant_any;
  logic        grant_id;
  logic [15:0] op_a, op_b;
  logic        op_id;
  logic [15:0] prod_lo;
  logic        prod_ovf;

`ifdef MULT_OVF_EN
  logic [31:0] prod_full;
  assign prod_full = {{16{op_a[15]}}, op_a} * {{16{op_b[15]}}, op_b};
  assign prod_lo   = prod_full[15:0];
  // Representable in 16 bits only when the top 17 bits are pure sign extension.
  assign prod_ovf  = !((&prod_full[31:15]) || !(|prod_full[31:15]));
`else
  assign prod_lo   = op_a * op_b;
  assign prod_ovf  = 1'b0;
`endif

  always_comb begin
    grant_id   = 1'b0;
    grant_any  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nxt  = state;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
    case (state)
      S_IDLE: begin
        // Gated by rst_n so neither requester sees a handshake during reset.
        grant_any  = rst_n && (req0_valid || req1_valid);
        req0_ready = grant_any && !grant_id;
        req1_ready = grant_any && grant_id;
        if (grant_any) state_nxt = S_CALC;
      end
      S_CALC:  state_nxt = S_DONE;
      S_DONE:  if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      op_a       <= 16'h0000;
      op_b       <= 16'h0000;
      op_id      <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= 16'h0000;
      res_id     <= 1'b0;
      res_ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        op_a       <= grant_id ? req1_a : req0_a;
        op_b       <= grant_id ? req1_b : req0_b;
        op_id      <= grant_id;
        last_grant <= grant_id;
      end
      if (state == S_CALC) begin
        res_valid <= 1'b1;
        res_data  <= prod_lo;
        res_id    <= op_id;
        res_ovf   <= prod_ovf;
      end
      if (state == S_DONE && res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - scoreboard bench for mult_share_ctrl
module tb_mult_share_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_id, res_ovf, res_ready;
  logic [15:0] res_data;

  int checks = 0;
  int failures = 0;
  logic [17:0] sb_q[$];

  always #5 clk = ~clk;

  mult_share_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ovf(res_ovf),
    .res_ready(res_ready)
  );

  function automatic logic [17:0] model(input logic id, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, p;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    p = sa * sb;
    ovf = (p > 32767) || (p < -32768);
`ifndef MULT_OVF_EN
    ovf = 1'b0;
`endif
    return {ovf, id, p[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push at grant, pop and compare at result handshake.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sb_q.delete();
    end else begin
      if (req0_ready) sb_q.push_back(model(1'b0, req0_a, req0_b));
      if (req1_ready) sb_q.push_back(model(1'b1, req1_a, req1_b));
      if (res_valid && res_ready) begin
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          logic [17:0] e;
          e = sb_q.pop_front();
          chk("sb_res_data", res_data, e[15:0]);
          chk("sb_res_id", res_id, e[16]);
          chk("sb_res_ovf", res_ovf, e[17]);
        end
      end
    end
  end

  initial begin
    logic [17:0] e;
    logic exp_w;
    int last_c, ngr;
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0002;
    req1_valid = 1'b0; req1_a = 16'h0; req1_b = 16'h0;

    // Reset, with a request held to show ready stays low.
    repeat (2) @(negedge clk);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1; req0_valid = 1'b0;
    @(negedge clk);
    chk("idle_res_valid", res_valid, 0);
    chk("idle_res_data", res_data, 16'h0000);
    chk("idle_res_id", res_id, 0);
    chk("idle_res_ovf", res_ovf, 0);
    chk("idle_req0_ready", req0_ready, 0);
    chk("idle_req1_ready", req1_ready, 0);

    // Single op: 3 * -5 on port 0.
    @(posedge clk); #1 req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'hFFFB; res_ready = 1'b1;
    @(negedge clk);
    chk("single_req0_ready", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    @(posedge clk); #1 req0_valid = 1'b0; req0_a = 16'h7777;
    @(negedge clk);
    chk("single_ready_pulse", req0_ready, 0);
    chk("single_calc_valid", res_valid, 0);
    @(negedge clk);
    chk("single_res_valid", res_valid, 1);
    chk("single_res_data", res_data, 16'hFFF1);
    chk("single_res_id", res_id, 0);
    @(negedge clk);
    chk("single_drop_valid", res_valid, 0);

    // Contention: port 0 won last, so port 1 wins next, then alternate every 3 cycles.
    @(posedge clk); #1 req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 16'($urandom); req0_b = 16'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
    exp_w = 1'b1; last_c = -1; ngr = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk("rr_winner", req1_ready, exp_w);
        chk("rr_one_hot", req0_ready & req1_ready, 0);
        if (last_c >= 0) chk("rr_gap", c - last_c, 3);
        exp_w = ~exp_w; last_c = c; ngr++;
      end
      @(posedge clk); #1
      req0_a = 16'($urandom); req0_b = 16'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
    end
    chk("rr_grants", ngr, 4);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure with wrap: port 1 wins (port 0 went last), result held 5 cycles.
    res_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h8000; req1_b = 16'hFFFF;
    req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0100;
    e = model(1'b1, 16'h8000, 16'hFFFF);
    @(negedge clk);
    chk("bp_req1_ready", req1_ready, 1);
    chk("bp_req0_ready", req0_ready, 0);
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_res_valid", res_valid, 1);
    chk("wrap_res_data", res_data, 16'h8000);
    chk("wrap_res_ovf", res_ovf, e[17]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_data", res_data, 16'h8000);
      chk("bp_hold_id", res_id, 1);
      chk("bp_no_ready", req0_ready, 0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_no_ready", req0_ready, 0);
    @(negedge clk);
    chk("bp_next_grant", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("zero_res_valid", res_valid, 1);
    chk("zero_res_data", res_data, 16'h0000);
    chk("zero_res_id", res_id, 0);
    @(negedge clk);

    // Mid-op reset during CALC, then port 0 wins first under contention.
    @(posedge clk); #1 req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0007;
    @(negedge clk);
    chk("mid_grant", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_data", res_data, 16'h0000);
    chk("mid_rst_ready", req1_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
    req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0003;
    @(negedge clk);
    chk("post_rst_req0_first", req0_ready, 1);
    chk("post_rst_req1_wait", req1_ready, 0);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    chk("sb_drained", sb_q.size(), 0);
    chk("end_res_valid", res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
